// File: rtl/anti_theft_fsm_if.sv
// ============================================================================
// Module      : anti_theft_fsm_if
// Description : Sensor/actuator bundle between the vehicle body and the
//               anti-theft controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface anti_theft_fsm_if;
    logic       one_hz_enable;
    logic       ignition;
    logic       door_driver;
    logic       door_pass;
    logic       siren;
    logic       status;
    logic       disarmed;
    logic [2:0] state;
    logic [3:0] time_left;

    modport master (
        output one_hz_enable, ignition, door_driver, door_pass,
        input  siren, status, disarmed, state, time_left
    );

    modport slave (
        input  one_hz_enable, ignition, door_driver, door_pass,
        output siren, status, disarmed, state, time_left
    );
endinterface

`default_nettype wire

// File: rtl/anti_theft_fsm.sv
// ============================================================================
// Module      : anti_theft_fsm
// Description : Vehicle anti-theft controller with door/ignition timeouts,
//               siren drive and blinking status LED.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module anti_theft_fsm #(
    parameter int unsigned T_ARM_DELAY       = 6,
    parameter int unsigned T_DRIVER_DELAY    = 8,
    parameter int unsigned T_PASSENGER_DELAY = 15,
    parameter int unsigned T_ALARM_ON        = 10
) (
    input  wire logic       clock,
    input  wire logic       reset,
    anti_theft_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        S_ARMED      = 3'd0,
        S_TRIGGERED  = 3'd1,
        S_ALARM      = 3'd2,
        S_DISARMED   = 3'd3,
        S_WAIT_CLOSE = 3'd4,
        S_ARM_DELAY  = 3'd5
    } state_t;

    localparam logic [3:0] c_arm_delay  = 4'(T_ARM_DELAY);
    localparam logic [3:0] c_drv_delay  = 4'(T_DRIVER_DELAY);
    localparam logic [3:0] c_pass_delay = 4'(T_PASSENGER_DELAY);
    localparam logic [3:0] c_alarm_on   = 4'(T_ALARM_ON);

    state_t     r_state;
    logic [3:0] r_timer;
    logic       r_blink;
    logic       r_siren;
    logic       r_status;
    logic       r_disarmed;

    state_t     w_next_state;
    logic [3:0] w_next_timer;
    logic       w_next_blink;
    logic [3:0] w_timer_dec;
    logic       w_any_door;
    logic       w_expired;

    assign w_any_door  = bus.door_driver | bus.door_pass;
    assign w_expired   = (r_timer == 4'd0);
    assign w_timer_dec = (bus.one_hz_enable && !w_expired) ? (r_timer - 4'd1) : r_timer;

    // Timer is forced to zero in untimed states; blink only survives while ARMED.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = 4'd0;
        w_next_blink = 1'b0;
        case (r_state)
            S_ARMED: begin
                if (bus.door_driver) begin
                    w_next_state = S_TRIGGERED;
                    w_next_timer = c_drv_delay;
                end else if (bus.door_pass) begin
                    w_next_state = S_TRIGGERED;
                    w_next_timer = c_pass_delay;
                end else begin
                    w_next_blink = r_blink ^ bus.one_hz_enable;
                end
            end
            S_TRIGGERED: begin
                if (bus.ignition) begin
                    w_next_state = S_DISARMED;
                end else if (w_expired) begin
                    w_next_state = S_ALARM;
                    w_next_timer = c_alarm_on;
                end else begin
                    w_next_timer = w_timer_dec;
                end
            end
            S_ALARM: begin
                if (w_any_door) begin
                    w_next_timer = c_alarm_on;
                end else if (w_expired) begin
                    w_next_state = S_ARMED;
                end else begin
                    w_next_timer = w_timer_dec;
                end
            end
            S_DISARMED: begin
                if (!bus.ignition && bus.door_driver) begin
                    w_next_state = S_WAIT_CLOSE;
                end
            end
            S_WAIT_CLOSE: begin
                if (bus.ignition) begin
                    w_next_state = S_DISARMED;
                end else if (!w_any_door) begin
                    w_next_state = S_ARM_DELAY;
                    w_next_timer = c_arm_delay;
                end
            end
            S_ARM_DELAY: begin
                if (bus.ignition) begin
                    w_next_state = S_DISARMED;
                end else if (w_any_door) begin
                    w_next_state = S_WAIT_CLOSE;
                end else if (w_expired) begin
                    w_next_state = S_ARMED;
                end else begin
                    w_next_timer = w_timer_dec;
                end
            end
            default: begin
                w_next_state = S_ARMED;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with r_state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_ARMED;
            r_timer    <= 4'd0;
            r_blink    <= 1'b0;
            r_siren    <= 1'b0;
            r_status   <= 1'b0;
            r_disarmed <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_timer    <= w_next_timer;
            r_blink    <= w_next_blink;
            r_siren    <= (w_next_state == S_ALARM);
            r_status   <= (w_next_state == S_ARMED) ? w_next_blink
                        : ((w_next_state == S_TRIGGERED) || (w_next_state == S_ALARM));
            r_disarmed <= (w_next_state == S_DISARMED) || (w_next_state == S_WAIT_CLOSE)
                        || (w_next_state == S_ARM_DELAY);
        end
    end

    assign bus.state     = r_state;
    assign bus.time_left = r_timer;
    assign bus.siren     = r_siren;
    assign bus.status    = r_status;
    assign bus.disarmed  = r_disarmed;

endmodule

`default_nettype wire
